// File: rtl/sm_run_ctrl.sv
// Run/debug sequencer for the schoolMIPS core: owns core reset and clock enable,
// executes host run/halt/step/reset commands and stops on breakpoint, budget or self-loop.
module sm_run_ctrl #(
   parameter int unsigned RST_CYCLES   = 4,
   parameter int unsigned MAX_CYCLES   = 0,
   parameter bit          START_HALTED = 1'b1,
   parameter logic [31:0] LOOP_INSTR   = 32'h1000FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_code,
   output logic        cmd_ready,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        cpu_rst_n,
   output logic        cpu_en,
   output logic [1:0]  state,
   output logic [2:0]  halt_cause,
   output logic [31:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   localparam logic [1:0]  CMD_RUN   = 2'd0;
   localparam logic [1:0]  CMD_HALT  = 2'd1;
   localparam logic [1:0]  CMD_STEP  = 2'd2;
   localparam logic [1:0]  CMD_RESET = 2'd3;

   localparam logic [2:0]  CAUSE_NONE    = 3'd0;
   localparam logic [2:0]  CAUSE_HOST    = 3'd1;
   localparam logic [2:0]  CAUSE_STEP    = 3'd2;
   localparam logic [2:0]  CAUSE_BP      = 3'd3;
   localparam logic [2:0]  CAUSE_TIMEOUT = 3'd4;
   localparam logic [2:0]  CAUSE_LOOP    = 3'd5;

   localparam logic [3:0]  HOLD_LAST = 4'(RST_CYCLES - 1);
   localparam logic [31:0] MAX_CNT   = 32'(MAX_CYCLES);

   state_t      state_r;
   state_t      nextState_s;
   logic [3:0]  holdCnt_r;
   logic [3:0]  nextHold_s;
   logic        cpuRstN_r;
   logic [31:0] cycleCnt_r;
   logic [2:0]  haltCause_r;
   logic [2:0]  nextCause_s;
   logic        skip_r;
   logic        nextSkip_s;
   logic        clearCnt_s;
   logic        cpuEn_s;
   logic        cmdAcc_s;

   // Next-state, stop-condition priority and core enable
   always_comb begin
      nextState_s = state_r;
      nextHold_s  = holdCnt_r;
      nextCause_s = haltCause_r;
      nextSkip_s  = skip_r;
      clearCnt_s  = 1'b0;
      cpuEn_s     = 1'b0;
      cmdAcc_s    = cmd_valid && (state_r != ST_HOLD);

      case (state_r)
         ST_HOLD: begin
            if (holdCnt_r == HOLD_LAST) begin
               nextHold_s = 4'd0;
               if (START_HALTED) begin
                  nextState_s = ST_HALT;
               end else begin
                  nextState_s = ST_RUN;
                  nextSkip_s  = 1'b1;
               end
            end else begin
               nextHold_s = holdCnt_r + 4'd1;
            end
         end
         ST_HALT: begin
            if (cmdAcc_s) begin
               case (cmd_code)
                  CMD_RUN: begin
                     nextState_s = ST_RUN;
                     nextSkip_s  = 1'b1;
                     nextCause_s = CAUSE_NONE;
                  end
                  CMD_STEP: begin
                     nextState_s = ST_STEP;
                  end
                  CMD_RESET: begin
                     nextState_s = ST_HOLD;
                     nextHold_s  = 4'd0;
                     nextCause_s = CAUSE_NONE;
                     clearCnt_s  = 1'b1;
                  end
                  default: begin
                     nextState_s = ST_HALT;
                  end
               endcase
            end else begin
               nextState_s = ST_HALT;
            end
         end
         ST_STEP: begin
            cpuEn_s = 1'b1;
            if (cmdAcc_s && (cmd_code == CMD_RESET)) begin
               nextState_s = ST_HOLD;
               nextHold_s  = 4'd0;
               nextCause_s = CAUSE_NONE;
               clearCnt_s  = 1'b1;
            end else begin
               nextState_s = ST_HALT;
               nextCause_s = CAUSE_STEP;
            end
         end
         ST_RUN: begin
            // skip only shields the very first RUN cycle after a resume
            nextSkip_s = 1'b0;
            if (cmdAcc_s && (cmd_code == CMD_RESET)) begin
               nextState_s = ST_HOLD;
               nextHold_s  = 4'd0;
               nextCause_s = CAUSE_NONE;
               clearCnt_s  = 1'b1;
            end else if (cmdAcc_s && (cmd_code == CMD_HALT)) begin
               nextState_s = ST_HALT;
               nextCause_s = CAUSE_HOST;
            end else if ((MAX_CNT != 32'd0) && (cycleCnt_r >= MAX_CNT)) begin
               nextState_s = ST_HALT;
               nextCause_s = CAUSE_TIMEOUT;
            end else if (bp_en && (pc == bp_addr) && !skip_r) begin
               nextState_s = ST_HALT;
               nextCause_s = CAUSE_BP;
            end else if ((instr == LOOP_INSTR) && !skip_r) begin
               nextState_s = ST_HALT;
               nextCause_s = CAUSE_LOOP;
            end else begin
               cpuEn_s = 1'b1;
            end
         end
         default: begin
            nextState_s = ST_HOLD;
            nextHold_s  = 4'd0;
            nextCause_s = CAUSE_NONE;
            clearCnt_s  = 1'b1;
         end
      endcase
   end

   // Sequencer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_HOLD;
         holdCnt_r   <= 4'd0;
         cpuRstN_r   <= 1'b0;
         cycleCnt_r  <= 32'd0;
         haltCause_r <= CAUSE_NONE;
         skip_r      <= 1'b0;
      end else begin
         state_r     <= nextState_s;
         holdCnt_r   <= nextHold_s;
         cpuRstN_r   <= (nextState_s != ST_HOLD);
         haltCause_r <= nextCause_s;
         skip_r      <= nextSkip_s;
         if (clearCnt_s) begin
            cycleCnt_r <= 32'd0;
         end else if (cpuEn_s) begin
            cycleCnt_r <= cycleCnt_r + 32'd1;
         end else begin
            cycleCnt_r <= cycleCnt_r;
         end
      end
   end

   assign cmd_ready  = (state_r != ST_HOLD);
   assign cpu_rst_n  = cpuRstN_r;
   assign cpu_en     = cpuEn_s;
   assign state      = state_r;
   assign halt_cause = haltCause_r;
   assign cycle_cnt  = cycleCnt_r;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Bench for sm_run_ctrl: halt events are scored against expectations queued when
// commands are issued; a small PC model stands in for the core.
module tb_sm_run_ctrl;

   localparam logic [31:0] LOOP = 32'h1000FFFF;
   localparam logic [1:0]  S_HOLD = 2'd0, S_HALT = 2'd1, S_RUN = 2'd2, S_STEP = 2'd3;
   localparam logic [1:0]  C_RUN = 2'd0, C_HALT = 2'd1, C_STEP = 2'd2, C_RESET = 2'd3;

   typedef struct {
      logic [2:0]  cause;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmdValid = 1'b0;
   logic [1:0]  cmdCode = 2'd0;
   logic        cmd_ready;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] instr;
   logic [31:0] loopPc = 32'hFFFF_FFFF;
   logic        cpu_rst_n, cpu_en;
   logic [1:0]  state;
   logic [2:0]  halt_cause;
   logic [31:0] cycle_cnt;

   logic        cmdValidB = 1'b0;
   logic [1:0]  cmdCodeB = 2'd0;
   logic        cmdReadyB;
   logic [31:0] pcB = 32'd0;
   logic        cpuRstNB, cpuEnB;
   logic [1:0]  stateB;
   logic [2:0]  causeB;
   logic [31:0] cntB;

   int   checks = 0;
   int   failures = 0;
   exp_t sbQ[$];
   logic [1:0] prevState = 2'd0;

   always #5 clk = ~clk;

   sm_run_ctrl #(.RST_CYCLES(4), .MAX_CYCLES(0), .START_HALTED(1'b1), .LOOP_INSTR(LOOP)) dutA (
      .clk(clk), .rst(rst), .cmd_valid(cmdValid), .cmd_code(cmdCode), .cmd_ready(cmd_ready),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
      .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .state(state),
      .halt_cause(halt_cause), .cycle_cnt(cycle_cnt));

   sm_run_ctrl #(.RST_CYCLES(4), .MAX_CYCLES(10), .START_HALTED(1'b0), .LOOP_INSTR(LOOP)) dutB (
      .clk(clk), .rst(rst), .cmd_valid(cmdValidB), .cmd_code(cmdCodeB), .cmd_ready(cmdReadyB),
      .bp_en(1'b0), .bp_addr(32'd0), .pc(pcB), .instr(32'd0),
      .cpu_rst_n(cpuRstNB), .cpu_en(cpuEnB), .state(stateB),
      .halt_cause(causeB), .cycle_cnt(cntB));

   // Core stand-ins: PC resets with the core and advances on every enabled cycle
   assign instr = (pc == loopPc) ? LOOP : 32'd0;
   always @(posedge clk) begin
      if (cpu_rst_n !== 1'b1) pc <= 32'd0;
      else if (cpu_en === 1'b1) pc <= pc + 32'd1;
   end
   always @(posedge clk) begin
      if (cpuRstNB !== 1'b1) pcB <= 32'd0;
      else if (cpuEnB === 1'b1) pcB <= pcB + 32'd1;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every entry into HALT must match the oldest queued expectation
   always @(negedge clk) begin
      if ((state === S_HALT) && (prevState !== S_HALT)) begin
         if (sbQ.size() == 0) begin
            checkVal("sb_unexpected_halt", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkVal("sb_cause", {29'd0, halt_cause}, {29'd0, e.cause});
            checkVal("sb_cnt", cycle_cnt, e.cnt);
         end
      end
      prevState = state;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic pushExp(input logic [2:0] cause, input logic [31:0] cnt);
      exp_t e;
      e.cause = cause;
      e.cnt   = cnt;
      sbQ.push_back(e);
   endtask

   task automatic sendCmd(input logic [1:0] code);
      @(posedge clk); #1;
      cmdValid = 1'b1;
      cmdCode  = code;
      @(posedge clk); #1;
      cmdValid = 1'b0;
   endtask

   task automatic sendCmdB(input logic [1:0] code);
      @(posedge clk); #1;
      cmdValidB = 1'b1;
      cmdCodeB  = code;
      @(posedge clk); #1;
      cmdValidB = 1'b0;
   endtask

   task automatic waitHalt(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state === S_HALT) begin
            seen = 1'b1;
            break;
         end
      end
      checkVal("halt_wait", {31'd0, seen}, 32'd1);
   endtask

   // Called right after the edge that starts a hold; ends in HALT
   task automatic checkHold(input string tag);
      int lowCnt = 0;
      bit bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpu_rst_n === 1'b0) begin
            lowCnt++;
            if ((cmd_ready !== 1'b0) || (cpu_en !== 1'b0) || (state !== S_HOLD) ||
                (cycle_cnt !== 32'd0) || (halt_cause !== 3'd0)) bad = 1'b1;
         end else begin
            break;
         end
      end
      checkVal({tag, "_low_cycles"}, lowCnt, 32'd4);
      checkVal({tag, "_hold_outputs"}, {31'd0, bad}, 32'd0);
      checkVal({tag, "_state"}, {30'd0, state}, {30'd0, S_HALT});
      checkVal({tag, "_cpu_en"}, {31'd0, cpu_en}, 32'd0);
      checkVal({tag, "_cnt"}, cycle_cnt, 32'd0);
      checkVal({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      bit found;

      // Power-on reset held a few edges; hold sequence then lands in HALT
      pushExp(3'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkHold("por");

      // Instance B starts running, exhausts its 10-instruction budget
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stateB === S_HALT) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("to_halted", {31'd0, found}, 32'd1);
      checkVal("to_cause", {29'd0, causeB}, 32'd4);
      checkVal("to_cnt", cntB, 32'd10);
      sendCmdB(C_RUN);
      @(negedge clk);
      checkVal("to_resume_state", {30'd0, stateB}, {30'd0, S_RUN});
      checkVal("to_resume_en", {31'd0, cpuEnB}, 32'd0);
      @(negedge clk);
      checkVal("to_rehalt_state", {30'd0, stateB}, {30'd0, S_HALT});
      checkVal("to_rehalt_cause", {29'd0, causeB}, 32'd4);
      checkVal("to_rehalt_cnt", cntB, 32'd10);

      // Three single steps, two cycles apart
      for (int n = 1; n <= 3; n++) begin
         pushExp(3'd2, 32'(n));
         sendCmd(C_STEP);
         @(negedge clk);
         checkVal("step_state", {30'd0, state}, {30'd0, S_STEP});
         checkVal("step_en", {31'd0, cpu_en}, 32'd1);
         @(negedge clk);
         checkVal("step_back", {30'd0, state}, {30'd0, S_HALT});
         @(posedge clk);
      end

      // Breakpoint at PC 5
      bp_en   = 1'b1;
      bp_addr = 32'd5;
      pushExp(3'd3, 32'd5);
      sendCmd(C_RUN);
      waitHalt(40);
      checkVal("bp_pc", pc, 32'd5);

      // Resume executes PC 5, then self-loop idiom at PC 7 stops the run
      loopPc = 32'd7;
      pushExp(3'd5, 32'd7);
      sendCmd(C_RUN);
      waitHalt(40);
      checkVal("loop_pc", pc, 32'd7);

      // Host HALT in the same cycle as a self-loop hit wins
      loopPc = 32'd9;
      pushExp(3'd1, 32'd9);
      sendCmd(C_RUN);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((pc === 32'd9) && (state === S_RUN)) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("hl_reach_pc9", {31'd0, found}, 32'd1);
      cmdValid = 1'b1;
      cmdCode  = C_HALT;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      waitHalt(4);

      // RESET command mid-run at cycle_cnt 20
      loopPc = 32'hFFFF_FFFF;
      bp_en  = 1'b0;
      sendCmd(C_RUN);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cycle_cnt === 32'd20) begin
            found = 1'b1;
            break;
         end
      end
      checkVal("rc_reach_20", {31'd0, found}, 32'd1);
      pushExp(3'd0, 32'd0);
      cmdValid = 1'b1;
      cmdCode  = C_RESET;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      checkHold("rcmd");

      // Synchronous rst together with a STEP command: reset wins
      pushExp(3'd0, 32'd0);
      @(posedge clk); #1;
      rst      = 1'b1;
      cmdValid = 1'b1;
      cmdCode  = C_STEP;
      @(posedge clk); #1;
      rst      = 1'b0;
      cmdValid = 1'b0;
      checkHold("rst_vs_step");

      repeat (2) @(negedge clk);
      checkVal("sb_remaining", sbQ.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sm_run_ctrl.md
Name: sm_run_ctrl

Overview:
- Run/debug sequencer for the single-cycle schoolMIPS core.
- Drives the core's reset and a per-cycle clock enable.
- Accepts host commands: run, halt, single-step, reset.
- Stops the core on one of four events:
  - PC breakpoint
  - cycle budget exhausted
  - self-loop end-of-program idiom (beq $0,$0,-1)
  - host halt command
- Sits between the board/host debug logic and sm_cpu. Replaces free-running bring-up with controlled execution and a retired-instruction count.

Parameters:
- RST_CYCLES, 4, cycles cpu_rst_n is held low after entering RESET_HOLD (range 1..15).
- MAX_CYCLES, 0, run budget in retired instructions; 0 disables the timeout.
- START_HALTED, 1, after the reset hold: 1 goes to HALT, 0 goes to RUN.
- LOOP_INSTR, 32'h1000FFFF, instruction encoding treated as end-of-program self-loop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  host command valid
- cmd_code  in  2  0=RUN 1=HALT 2=STEP 3=RESET
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC, word address (same units as core PC)
- pc  in  32  current core PC, word address
- instr  in  32  instruction currently fetched by the core
- cpu_rst_n  out  1  core reset, active-low, registered
- cpu_en  out  1  core clock enable; core commits one instruction per cycle with cpu_en=1
- state  out  2  0=RESET_HOLD 1=HALT 2=RUN 3=STEP
- halt_cause  out  3  0=none 1=host 2=step 3=breakpoint 4=timeout 5=self-loop
- cycle_cnt  out  32  retired instruction count

Behaviour:
- rst=1 (sampled at clk edge): state=RESET_HOLD, hold counter=0, cpu_rst_n=0, cycle_cnt=0, halt_cause=0, skip=0. Overrides any command in the same cycle.
- cpu_en is combinational: 0 in RESET_HOLD and HALT; 1 in STEP; in RUN, 1 unless a stop condition (below) is active this cycle.
- cycle_cnt increments on each cycle with cpu_en=1; wraps at 2^32-1 to 0, no flag.
- cmd_ready = (state != RESET_HOLD).
- RESET_HOLD:
  - hold counter increments each cycle.
  - When it reaches RST_CYCLES-1: cpu_rst_n goes 1 next cycle, and state goes to HALT (START_HALTED=1) or RUN with skip=1 (START_HALTED=0).
- HALT:
  - RUN cmd: state=RUN, skip=1, halt_cause=0.
  - STEP cmd: state=STEP.
  - HALT cmd: no-op.
  - RESET cmd: RESET_HOLD, cycle_cnt=0, halt_cause=0.
- STEP: exactly one cycle with cpu_en=1; the next state is always HALT with halt_cause=2. Breakpoint, timeout and self-loop are not evaluated. Commands arriving in STEP are accepted and ignored, except RESET, which takes effect.
- RUN stop conditions, evaluated each cycle in priority order:
  1. RESET cmd
  2. HALT cmd (cause 1)
  3. timeout: MAX_CYCLES!=0 && cycle_cnt>=MAX_CYCLES (cause 4)
  4. breakpoint: bp_en && pc==bp_addr && !skip (cause 3)
  5. self-loop: instr==LOOP_INSTR && !skip (cause 5)
- Any active stop condition forces cpu_en=0 in that cycle, so the instruction at pc is not executed. The next state is HALT (RESET_HOLD for RESET) with the winning cause latched.
- skip clears after the first RUN cycle. This lets RUN resume from a breakpoint or self-loop PC and execute that instruction once. Timeout is not affected by skip.
- RUN and STEP commands received while in RUN are ignored. RESET in any non-hold state restarts the hold sequence from count 0.
- Resuming after a timeout halts again immediately (cause 4) until RESET.

Test Plan:
- Reset, START_HALTED=1, RST_CYCLES=4 -> cpu_rst_n=0 for 4 cycles, then state=HALT, cpu_en=0, cycle_cnt=0, cmd_ready=0 during the hold.
- From HALT, 3x STEP cmds spaced 2 cycles apart -> exactly 3 single-cycle cpu_en pulses, cycle_cnt=3, halt_cause=2 after each step.
- RUN with bp_en=1, bp_addr=5, pc advancing 0,1,2… -> cpu_en=0 in the cycle pc==5, state=HALT, cause=3, cycle_cnt=5. Second RUN -> pc 5 executes, run continues.
- MAX_CYCLES=10, RUN -> halt with cycle_cnt=10, cause=4. Second RUN -> immediate halt, cycle_cnt stays 10.
- instr=32'h1000FFFF appears at pc=7 while running -> halt cause=5, cycle_cnt=7. Same cycle with a HALT cmd -> cause=1.
- RESET cmd mid-RUN at cycle_cnt=20 -> state=RESET_HOLD, cpu_rst_n=0 for RST_CYCLES, cycle_cnt=0, cause=0. Synchronous rst asserted with a simultaneous STEP -> reset wins.
